retry_fail_arbiter: RTL and testbench

//  Merges failed-ID retry requests from NUM_REQ retry_end instances onto the single

---
 rtl/retry_fail_arbiter_if.sv | 32 +++
 rtl/retry_fail_arbiter.sv | 131 +++++++++++++
 tb/tb_retry_fail_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/retry_fail_arbiter_if.sv
// rtl/retry_fail_arbiter_if.sv - failed-ID request/retry handshake bundle for retry_fail_arbiter
//
// Signal names are from the arbiter's point of view:
//   failed_id_i     NUM_REQ*ID_SIZE  failed ID per requester
//   failed_valid_i  NUM_REQ          failed ID valid per requester
//   failed_ready_o  NUM_REQ          grant per requester
//   failed_id_o     ID_SIZE          ID forwarded to retry_start
//   failed_valid_o  1                retry request valid
//   failed_ready_i  1                retry_start ready
// slave  : arbiter side
// master : requester + retry_start side (testbench / integration)
interface retry_fail_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ID_SIZE = 2
);
   logic [NUM_REQ*ID_SIZE-1:0] failed_id_i;
   logic [NUM_REQ-1:0]         failed_valid_i;
   logic [NUM_REQ-1:0]         failed_ready_o;
   logic [ID_SIZE-1:0]         failed_id_o;
   logic                       failed_valid_o;
   logic                       failed_ready_i;

   modport slave (
      input  failed_id_i, failed_valid_i, failed_ready_i,
      output failed_ready_o, failed_id_o, failed_valid_o
   );

   modport master (
      output failed_id_i, failed_valid_i, failed_ready_i,
      input  failed_ready_o, failed_id_o, failed_valid_o
   );
endinterface

// File: rtl/retry_fail_arbiter.sv
// rtl/retry_fail_arbiter.sv - round-robin failed-ID merger with per-ID retry budget
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   bus (slave)           requester handshakes in, single retry request out
//   done_id_i/done_valid_i  completion strobe, clears the budget of that ID
//   abort_id_o/abort_valid_o  one-cycle pulse for an ID whose budget ran out
// Optional feature macro: RETRY_FAIL_ARBITER_STATS_EN
//   adds retry_total_o[31:0] (slot loads) and abort_total_o[15:0] (abort pulses),
//   both saturating.
module retry_fail_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ID_SIZE     = 2,
   parameter int MAX_RETRIES = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   retry_fail_arbiter_if.slave bus,
   input  logic [ID_SIZE-1:0] done_id_i,
   input  logic               done_valid_i,
   output logic [ID_SIZE-1:0] abort_id_o,
   output logic               abort_valid_o
`ifdef RETRY_FAIL_ARBITER_STATS_EN
   ,
   output logic [31:0]        retry_total_o,
   output logic [15:0]        abort_total_o
`endif
);
   localparam int CNT_W  = $clog2(MAX_RETRIES + 1);
   localparam int NUM_ID = 2 ** ID_SIZE;
   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic               valid_q, valid_d;
   logic [ID_SIZE-1:0] id_q, id_d;
   logic               abort_valid_q, abort_valid_d;
   logic [ID_SIZE-1:0] abort_id_q, abort_id_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   cnt_q [NUM_ID];
   logic [CNT_W-1:0]   cnt_d [NUM_ID];

   logic               slot_free;
   logic               found;
   logic [PTR_W-1:0]   win;
   logic [ID_SIZE-1:0] win_id;
   logic               grant;
   logic               fwd;

   // Winner search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         automatic int idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.failed_valid_i[idx]) begin
            found = 1'b1;
            win   = PTR_W'(idx);
         end
      end
   end

   assign slot_free = !valid_q || bus.failed_ready_i;
   assign grant     = found && slot_free;
   assign win_id    = bus.failed_id_i[int'(win)*ID_SIZE +: ID_SIZE];
   // Limit check uses the count before any same-cycle done clear.
   assign fwd       = grant && (cnt_q[win_id] < CNT_W'(MAX_RETRIES));

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.failed_ready_o[i] = grant && (int'(win) == i);
      end
   end

   always_comb begin
      valid_d       = slot_free ? fwd : valid_q;
      id_d          = fwd ? win_id : id_q;
      abort_valid_d = grant && !fwd;
      abort_id_d    = (grant && !fwd) ? win_id : abort_id_q;
      rr_ptr_d      = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
      end
      for (int k = 0; k < NUM_ID; k++) begin
         cnt_d[k] = cnt_q[k];
         if (done_valid_i && done_id_i == ID_SIZE'(k)) cnt_d[k] = '0;
         // A forward only happens below MAX_RETRIES, so +1 never wraps.
         if (grant && win_id == ID_SIZE'(k)) cnt_d[k] = fwd ? cnt_d[k] + CNT_W'(1) : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q       <= 1'b0;
         id_q          <= '0;
         abort_valid_q <= 1'b0;
         abort_id_q    <= '0;
         rr_ptr_q      <= '0;
         for (int k = 0; k < NUM_ID; k++) cnt_q[k] <= '0;
      end else begin
         valid_q       <= valid_d;
         id_q          <= id_d;
         abort_valid_q <= abort_valid_d;
         abort_id_q    <= abort_id_d;
         rr_ptr_q      <= rr_ptr_d;
         for (int k = 0; k < NUM_ID; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   assign bus.failed_valid_o = valid_q;
   assign bus.failed_id_o    = id_q;
   assign abort_valid_o      = abort_valid_q;
   assign abort_id_o         = abort_id_q;

`ifdef RETRY_FAIL_ARBITER_STATS_EN
   logic [31:0] retry_total_q;
   logic [15:0] abort_total_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         retry_total_q <= '0;
         abort_total_q <= '0;
      end else begin
         if (fwd && retry_total_q != '1) retry_total_q <= retry_total_q + 32'd1;
         if (abort_valid_d && abort_total_q != '1) abort_total_q <= abort_total_q + 16'd1;
      end
   end

   assign retry_total_o = retry_total_q;
   assign abort_total_o = abort_total_q;
`endif
endmodule

// File: tb/tb_retry_fail_arbiter.sv
// tb/tb_retry_fail_arbiter.sv - scoreboard bench for retry_fail_arbiter
module tb_retry_fail_arbiter;
   localparam int N   = 2;
   localparam int W   = 2;
   localparam int MAX = 3;

   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   logic [W-1:0] done_id_i = '0;
   logic         done_valid_i = 1'b0;
   logic [W-1:0] abort_id_o;
   logic         abort_valid_o;
`ifdef RETRY_FAIL_ARBITER_STATS_EN
   logic [31:0]  retry_total_o;
   logic [15:0]  abort_total_o;
`endif

   retry_fail_arbiter_if #(.NUM_REQ(N), .ID_SIZE(W)) bus ();

   retry_fail_arbiter #(.NUM_REQ(N), .ID_SIZE(W), .MAX_RETRIES(MAX)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .bus           (bus),
      .done_id_i     (done_id_i),
      .done_valid_i  (done_valid_i),
      .abort_id_o    (abort_id_o),
      .abort_valid_o (abort_valid_o)
`ifdef RETRY_FAIL_ARBITER_STATS_EN
      ,
      .retry_total_o (retry_total_o),
      .abort_total_o (abort_total_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_cnt [2**W];
   int m_rr;
   int m_full;
   int m_last_win;
   int m_retry;
   int m_abort;
   int exp_fwd [$];
   int exp_abt [$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2**W; k++) m_cnt[k] = 0;
      m_rr = 0; m_full = 0; m_last_win = -1; m_retry = 0; m_abort = 0;
      exp_fwd.delete();
      exp_abt.delete();
   endtask

   // One clock of stimulus plus the model's prediction for it.
   task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] ids, input logic rdy,
                       input logic dv, input logic [W-1:0] did);
      int sf, win, x, pre;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      bus.failed_valid_i = v;
      bus.failed_id_i    = ids;
      bus.failed_ready_i = rdy;
      done_valid_i       = dv;
      done_id_i          = did;
      #1;
      chk("valid_o", int'(bus.failed_valid_o), m_full);
      sf  = (m_full == 0 || rdy) ? 1 : 0;
      win = -1;
      if (sf != 0) begin
         for (int k = 0; k < N; k++) begin
            if (win < 0 && v[(m_rr + k) % N]) win = (m_rr + k) % N;
         end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("ready_o", int'(bus.failed_ready_o), int'(exp_rdy));
      pre = 0;
      x   = 0;
      if (win >= 0) begin
         x   = int'(ids[win*W +: W]);
         pre = m_cnt[x];
      end
      if (dv) m_cnt[did] = 0;
      if (win >= 0) begin
         if (pre < MAX) begin
            m_cnt[x] = m_cnt[x] + 1;
            exp_fwd.push_back(x);
            m_retry++;
         end else begin
            m_cnt[x] = 0;
            exp_abt.push_back(x);
            m_abort++;
         end
         m_rr = (win + 1) % N;
      end
      if (sf != 0) m_full = (win >= 0 && pre < MAX) ? 1 : 0;
      m_last_win = win;
   endtask

   // Monitor: pops expectations whenever the DUT presents a handshake or abort.
   always begin
      @(negedge clk);
      #2;
      if (rst_ni) begin
         if (bus.failed_valid_o && bus.failed_ready_i) begin
            if (exp_fwd.size() == 0) chk("fwd_unexpected", int'(bus.failed_id_o), -1);
            else chk("fwd_id", int'(bus.failed_id_o), exp_fwd.pop_front());
         end
         if (abort_valid_o) begin
            if (exp_abt.size() == 0) chk("abort_unexpected", int'(abort_id_o), -1);
            else chk("abort_id", int'(abort_id_o), exp_abt.pop_front());
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid_o"}, int'(bus.failed_valid_o), 0);
      chk({tag, "_id_o"}, int'(bus.failed_id_o), 0);
      chk({tag, "_abort_valid"}, int'(abort_valid_o), 0);
      chk({tag, "_abort_id"}, int'(abort_id_o), 0);
`ifdef RETRY_FAIL_ARBITER_STATS_EN
      chk({tag, "_retry_total"}, int'(retry_total_o), 0);
      chk({tag, "_abort_total"}, int'(abort_total_o), 0);
`endif
   endtask

   logic [N-1:0]   pend;
   logic [N*W-1:0] pids;

   initial begin
      bus.failed_valid_i = '0;
      bus.failed_id_i    = '0;
      bus.failed_ready_i = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_ni = 1'b1;

      // Both requesters valid: alternating grants, IDs 1,2,1,2.
      repeat (4) step(2'b11, {2'd2, 2'd1}, 1'b1, 1'b0, 2'd0);
      step(2'b00, '0, 1'b1, 1'b1, 2'd1);
      step(2'b00, '0, 1'b1, 1'b1, 2'd2);

      // ID 3 four times from requester 0: fourth aborts.
      repeat (4) step(2'b01, {2'd0, 2'd3}, 1'b1, 1'b0, 2'd0);

      // ID 2 twice, done, three more: no abort.
      repeat (2) step(2'b10, {2'd2, 2'd0}, 1'b1, 1'b0, 2'd0);
      step(2'b00, '0, 1'b1, 1'b1, 2'd2);
      repeat (3) step(2'b10, {2'd2, 2'd0}, 1'b1, 1'b0, 2'd0);

      // Stall with the slot full for 5 cycles, then release.
      step(2'b00, '0, 1'b1, 1'b1, 2'd0);
      step(2'b00, '0, 1'b1, 1'b1, 2'd1);
      step(2'b01, {2'd1, 2'd0}, 1'b0, 1'b0, 2'd0);
      repeat (5) step(2'b11, {2'd1, 2'd0}, 1'b0, 1'b0, 2'd0);
      step(2'b11, {2'd1, 2'd0}, 1'b1, 1'b0, 2'd0);
      step(2'b00, '0, 1'b1, 1'b0, 2'd0);

      // Done and grant on ID 1 (cnt=2) in the same cycle, then exhaust it.
      step(2'b00, '0, 1'b1, 1'b1, 2'd1);
      repeat (2) step(2'b01, {2'd0, 2'd1}, 1'b1, 1'b0, 2'd0);
      step(2'b01, {2'd0, 2'd1}, 1'b1, 1'b1, 2'd1);
      repeat (3) step(2'b01, {2'd0, 2'd1}, 1'b1, 1'b0, 2'd0);

      // Asynchronous reset while the slot holds a request.
      step(2'b00, '0, 1'b1, 1'b1, 2'd0);
      step(2'b01, {2'd0, 2'd0}, 1'b0, 1'b0, 2'd0);
      step(2'b00, '0, 1'b0, 1'b0, 2'd0);
      chk("pre_reset_valid", int'(bus.failed_valid_o), 1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      bus.failed_valid_i = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      // ID 2 exhausted its budget earlier; after reset it gets three fresh retries.
      repeat (3) step(2'b10, {2'd2, 2'd0}, 1'b1, 1'b0, 2'd0);
      step(2'b10, {2'd2, 2'd0}, 1'b1, 1'b0, 2'd0);

      // Random traffic; requesters hold their ID until granted.
      pend = '0;
      pids = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int j = 0; j < N; j++) begin
            if (!pend[j]) begin
               pend[j] = ($urandom_range(0, 2) != 0);
               pids[j*W +: W] = W'($urandom_range(0, 2**W - 1));
            end
         end
         step(pend, pids, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
              W'($urandom_range(0, 2**W - 1)));
         if (m_last_win >= 0) pend[m_last_win] = 1'b0;
      end

      repeat (3) step('0, '0, 1'b1, 1'b0, 2'd0);
      #5;
      chk("fwd_left", exp_fwd.size(), 0);
      chk("abort_left", exp_abt.size(), 0);
`ifdef RETRY_FAIL_ARBITER_STATS_EN
      chk("retry_total", int'(retry_total_o), m_retry);
      chk("abort_total", int'(abort_total_o), m_abort);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
